canvas_serializer: RTL and testbench

- Sits between canvas_editor and neural_network.
- On Start, freezes the 28x28 drawing canvas via Hold, waits a settle window, then streams every pixel in row-major order over a valid/ready interface into the network's input loader.
- Each pixel is quantized from canvas width to network input width (round, saturate).
- Accumulates total ink so firmware and NN control can skip inference on a blank canvas.

---
 rtl/canvas_serializer.sv | 114 +++++++++++
 tb/tb_canvas_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/canvas_serializer.sv
// canvas_serializer: freezes the drawing canvas, then streams quantized pixels row-major over valid/ready while summing ink
module canvas_serializer #(
  parameter int ROWS          = 28,
  parameter int COLS          = 28,
  parameter int PIX_W         = 16,
  parameter int OUT_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDX_W         = 10,
  parameter int SUM_W         = 20
) (
  input  logic                                   Clk,
  input  logic                                   Reset_n,
  input  logic                                   Start,
  input  logic [ROWS-1:0][COLS-1:0][PIX_W-1:0]   canvas,
  output logic                                   Hold,
  output logic                                   Busy,
  output logic [OUT_W-1:0]                       Pix_Data,
  output logic [IDX_W-1:0]                       Pix_Index,
  output logic                                   Pix_Valid,
  input  logic                                   Pix_Ready,
  output logic                                   Pix_Last,
  output logic                                   Done,
  output logic [SUM_W-1:0]                       Ink_Sum,
  output logic                                   Empty
);
  localparam int SH  = PIX_W - OUT_W;
  localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int CW  = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS * COLS - 1);
  localparam logic [PIX_W:0]   HALF = SH == 0 ? '0 : (PIX_W + 1)'(1) << (SH == 0 ? 0 : SH - 1);
  localparam logic [PIX_W:0]   MAXV = (PIX_W + 1)'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, STREAM, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    row, row_n;
  logic [CLW-1:0]   col, col_n;
  logic             xfer, settled, wrap;
  logic [SUM_W-1:0] sum_n;

  function automatic logic [OUT_W-1:0] quant(input logic [PIX_W-1:0] v);
    logic [PIX_W:0] r;
    r = ({1'b0, v} + HALF) >> SH;
    return SH == 0 ? v[OUT_W-1:0] : (r > MAXV ? '1 : r[OUT_W-1:0]);
  endfunction

  assign xfer      = Pix_Valid & Pix_Ready;
  assign settled   = cnt == CW'(SETTLE_CYCLES - 1);
  assign wrap      = col == CLW'(COLS - 1);
  assign col_n     = wrap ? '0 : col + 1'b1;
  assign row_n     = wrap ? row + 1'b1 : row;
  assign sum_n     = Ink_Sum + SUM_W'(Pix_Data);
  assign Hold      = state == SETTLE || state == STREAM;
  assign Busy      = Hold;
  assign Pix_Valid = state == STREAM;
  assign Pix_Last  = Pix_Valid && Pix_Index == LAST;
  assign Done      = state == DONE;

  // state register; reset aborts any pass in flight
  always_ff @(posedge Clk)
    state <= !Reset_n ? IDLE : state_n;

  // next state: Start only honoured in IDLE, DONE lasts a single cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = Start ? SETTLE : IDLE;
      SETTLE:  state_n = settled ? STREAM : SETTLE;
      STREAM:  state_n = xfer && Pix_Last ? DONE : STREAM;
      default: state_n = IDLE;
    endcase
  end

  // datapath: settle counter, pixel fetch/quantize, ink accumulation
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      Pix_Data  <= '0;
      Pix_Index <= '0;
      Ink_Sum   <= '0;
      Empty     <= 1'b0;
    end else begin
      if (state == IDLE && Start) begin
        cnt     <= '0;
        Ink_Sum <= '0;
        Empty   <= 1'b0;
      end
      if (state == SETTLE) begin
        cnt <= cnt + 1'b1;
        if (settled) begin
          Pix_Data  <= quant(canvas[0][0]);
          Pix_Index <= '0;
          row       <= '0;
          col       <= '0;
        end
      end
      if (state == STREAM && xfer) begin
        Ink_Sum <= sum_n;
        if (Pix_Last)
          Empty <= sum_n == '0;
        else begin
          Pix_Data  <= quant(canvas[row_n][col_n]);
          Pix_Index <= Pix_Index + 1'b1;
          row       <= row_n;
          col       <= col_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_canvas_serializer.sv
// tb_canvas_serializer: directed passes over canvas_serializer with a per-beat reference model
module tb_canvas_serializer;
  localparam int R = 28, C = 28, N = R * C, S = 4;

  logic                        Clk = 0, Reset_n = 0, Start = 0, Pix_Ready = 0;
  logic [R-1:0][C-1:0][15:0]   canvas;
  logic                        Hold, Busy, Pix_Valid, Pix_Last, Done, Empty;
  logic [7:0]                  Pix_Data;
  logic [9:0]                  Pix_Index;
  logic [19:0]                 Ink_Sum;

  int checks = 0, errors = 0;
  int beats, dones, vn, done_n;
  logic [19:0] exp_sum;
  logic [7:0]  cap [N];

  typedef struct {int idx; logic [15:0] v; logic [7:0] q;} qvec_t;
  qvec_t tbl [8];

  canvas_serializer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .canvas(canvas),
    .Hold(Hold), .Busy(Busy), .Pix_Data(Pix_Data), .Pix_Index(Pix_Index),
    .Pix_Valid(Pix_Valid), .Pix_Ready(Pix_Ready), .Pix_Last(Pix_Last),
    .Done(Done), .Ink_Sum(Ink_Sum), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] qm(input logic [15:0] v);
    int t;
    t = (int'(v) + 128) / 256;
    return t > 255 ? 8'hFF : 8'(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ramp();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        canvas[r][c] = 16'((r * C + c) << 8);
  endtask

  task automatic run_pass(input int pct, input bit poke, input int abort);
    bit stall = 0;
    logic [7:0] pd = '0;
    logic [9:0] pi = '0;
    int n = 0;
    beats = 0; dones = 0; vn = -1; done_n = -1; exp_sum = '0;
    @(negedge Clk); Start = 1;
    @(posedge Clk);
    @(negedge Clk); Start = 0;
    chk("start_hold", Hold, 1);
    chk("start_busy", Busy, 1);
    chk("start_sum", Ink_Sum, 0);
    chk("start_empty", Empty, 0);
    while (n < 12000 && (done_n < 0 || n < done_n + 5)) begin
      if (Done) begin
        dones++;
        if (done_n < 0) begin
          done_n = n;
          chk("done_busy", Busy, 0);
          chk("done_hold", Hold, 0);
          chk("done_sum", Ink_Sum, exp_sum);
          chk("done_empty", Empty, exp_sum == 0);
        end
      end
      if (Pix_Valid) begin
        if (vn < 0) vn = n;
        chk("hold_stream", Hold, 1);
        if (stall) begin
          chk("stall_data", Pix_Data, pd);
          chk("stall_index", Pix_Index, pi);
        end
      end
      if (abort >= 0 && beats == abort) begin
        Reset_n = 0;
        @(negedge Clk);
        Reset_n = 1;
        chk("abort_valid", Pix_Valid, 0);
        chk("abort_hold", Hold, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_sum", Ink_Sum, 0);
        chk("abort_index", Pix_Index, 0);
        chk("abort_data", Pix_Data, 0);
        chk("abort_done", Done, 0);
        return;
      end
      Pix_Ready = $urandom_range(99) < pct;
      if (Pix_Valid && Pix_Ready) begin
        chk("index", Pix_Index, beats);
        chk("last", Pix_Last, beats == N - 1);
        if (beats < N) begin
          chk("data", Pix_Data, qm(canvas[beats / C][beats % C]));
          exp_sum = exp_sum + 20'(qm(canvas[beats / C][beats % C]));
          cap[beats] = Pix_Data;
        end
        beats++;
      end
      stall = Pix_Valid && !Pix_Ready;
      pd = Pix_Data;
      pi = Pix_Index;
      Start = poke && beats == 300;
      @(negedge Clk);
      n++;
    end
    Start = 0;
    chk("pass_finished", done_n >= 0, 1);
    chk("beats", beats, N);
    chk("dones", dones, 1);
    chk("sum_hold", Ink_Sum, exp_sum);
    chk("empty_hold", Empty, exp_sum == 0);
    if (pct == 100) begin
      chk("first_valid_time", vn, S);
      chk("done_time", done_n, S + N);
    end
  endtask

  initial begin
    int bad;
    tbl[0] = '{0,   16'h0080, 8'h01};
    tbl[1] = '{1,   16'h007F, 8'h00};
    tbl[2] = '{2,   16'h7F7F, 8'h7F};
    tbl[3] = '{3,   16'hFF80, 8'hFF};
    tbl[4] = '{4,   16'hFFFF, 8'hFF};
    tbl[5] = '{27,  16'h1234, 8'h12};
    tbl[6] = '{28,  16'h00FF, 8'h01};
    tbl[7] = '{783, 16'hABCD, 8'hAC};
    canvas = '0;
    Reset_n = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    chk("rst_valid", Pix_Valid, 0);
    chk("rst_hold", Hold, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sum", Ink_Sum, 0);
    chk("rst_empty", Empty, 0);
    bad = 0;
    repeat (1000) begin
      @(negedge Clk);
      if ({Hold, Busy, Pix_Valid, Pix_Last, Done, Empty} != 6'b0 || Pix_Data != 0 || Pix_Index != 0 || Ink_Sum != 0)
        bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    ramp();
    run_pass(100, 0, -1);
    chk("ramp_sum", Ink_Sum, 98040);
    chk("ramp_empty", Empty, 0);
    canvas = '0;
    foreach (tbl[i]) canvas[tbl[i].idx / C][tbl[i].idx % C] = tbl[i].v;
    run_pass(100, 0, -1);
    foreach (tbl[i]) chk($sformatf("quant_%0d", tbl[i].idx), cap[tbl[i].idx], tbl[i].q);
    chk("quant_sum", Ink_Sum, 829);
    ramp();
    run_pass(30, 0, -1);
    canvas = '0;
    run_pass(100, 1, -1);
    chk("zero_sum", Ink_Sum, 0);
    chk("zero_empty", Empty, 1);
    ramp();
    run_pass(100, 0, 400);
    run_pass(100, 0, -1);
    chk("restart_sum", Ink_Sum, 98040);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
